matrix_add_arbiter: RTL and testbench

Sequencer/arbiter that shares a single combinational matrix adder (`AddUnit`) between two requesters, e.g. the input-entry path and the calculation path. It takes requests as single-cycle pulses and chooses one requester round-robin. It drives the adder operands from registers, waits a fixed settle time, captures the sum and error status, then returns a one-cycle done pulse to the requester that was served. Dimension checking is done first, so illegal sizes never reach the adder.

---
 rtl/matrix_add_arbiter.sv | 144 ++++++++++++++
 tb/tb_matrix_add_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_add_arbiter.sv
// Round-robin sequencer that shares one combinational matrix adder between two requesters.
// Define MATRIX_ADD_ARB_FIXED_PRI_EN for fixed priority (requester 0 wins simultaneous requests).
module matrix_add_arbiter #(
  parameter int ELEM_W        = 8,
  parameter int MAX_DIM       = 5,
  parameter int SETTLE_CYCLES = 1,
  localparam int MW           = MAX_DIM * MAX_DIM * ELEM_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [2:0]    m0,
  input  logic [2:0]    n0,
  input  logic [MW-1:0] a0,
  input  logic [MW-1:0] b0,
  input  logic          req1,
  input  logic [2:0]    m1,
  input  logic [2:0]    n1,
  input  logic [MW-1:0] a1,
  input  logic [MW-1:0] b1,
  output logic [2:0]    au_m,
  output logic [2:0]    au_n,
  output logic [MW-1:0] au_a,
  output logic [MW-1:0] au_b,
  input  logic [MW-1:0] au_sum,
  input  logic          au_valid,
  input  logic          au_error,
  output logic [MW-1:0] result,
  output logic          result_err,
  output logic          done0,
  output logic          done1,
  output logic          busy,
  output logic          owner
);

  localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]    DIM_MAX  = 4'(MAX_DIM);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REJ
  } state_t;

  state_t        state, state_nxt;
  logic          pend0, pend1;
  logic [CW-1:0] cnt;
  logic          grant, win, win_ok;
  logic          cap_run, cap_rej;

  function automatic logic dims_ok(input logic [2:0] m, input logic [2:0] n);
    return (m != 3'd0) && ({1'b0, m} <= DIM_MAX) &&
           (n != 3'd0) && ({1'b0, n} <= DIM_MAX);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    win       = 1'b0;
    win_ok    = 1'b0;
    cap_run   = 1'b0;
    cap_rej   = 1'b0;
`ifdef MATRIX_ADD_ARB_FIXED_PRI_EN
    win = ~pend0;
`else
    // On a tie the requester that was not served last wins.
    win = (pend0 && pend1) ? ~owner : pend1;
`endif
    win_ok = win ? dims_ok(m1, n1) : dims_ok(m0, n0);
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          grant     = 1'b1;
          state_nxt = win_ok ? RUN : REJ;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          cap_run   = 1'b1;
          state_nxt = IDLE;
        end
      end
      REJ: begin
        cap_rej   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend0      <= 1'b0;
      pend1      <= 1'b0;
      owner      <= 1'b1;
      cnt        <= '0;
      au_m       <= '0;
      au_n       <= '0;
      au_a       <= '0;
      au_b       <= '0;
      result     <= '0;
      result_err <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      // A request arriving on the granting edge re-arms the pending bit.
      pend0 <= (pend0 & ~(grant & ~win)) | req0;
      pend1 <= (pend1 & ~(grant & win)) | req1;

      if (grant) begin
        owner <= win;
        cnt   <= '0;
        if (win_ok) begin
          au_m <= win ? m1 : m0;
          au_n <= win ? n1 : n0;
          au_a <= win ? a1 : a0;
          au_b <= win ? b1 : b0;
        end
      end else if (state == RUN && !cap_run) begin
        cnt <= cnt + 1'b1;
      end

      if (cap_run) begin
        result     <= au_sum;
        result_err <= au_error | ~au_valid;
      end else if (cap_rej) begin
        result     <= '0;
        result_err <= 1'b1;
      end

      done0 <= (cap_run | cap_rej) & ~owner;
      done1 <= (cap_run | cap_rej) & owner;
    end
  end

endmodule

// File: tb/tb_matrix_add_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter plus a behavioural adder.
module tb_matrix_add_arbiter;

  localparam int ELEM_W  = 8;
  localparam int MAX_DIM = 5;
  localparam int SETTLE  = 1;
  localparam int MW      = MAX_DIM * MAX_DIM * ELEM_W;
`ifdef MATRIX_ADD_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk, reset;
  logic          req0, req1;
  logic [2:0]    m0, n0, m1, n1;
  logic [MW-1:0] a0, b0, a1, b1;
  logic [2:0]    au_m, au_n;
  logic [MW-1:0] au_a, au_b, au_sum, result;
  logic          au_valid, au_error, result_err, done0, done1, busy, owner;

  matrix_add_arbiter #(
    .ELEM_W       (ELEM_W),
    .MAX_DIM      (MAX_DIM),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .m0(m0), .n0(n0), .a0(a0), .b0(b0),
    .req1(req1), .m1(m1), .n1(n1), .a1(a1), .b1(b1),
    .au_m(au_m), .au_n(au_n), .au_a(au_a), .au_b(au_b),
    .au_sum(au_sum), .au_valid(au_valid), .au_error(au_error),
    .result(result), .result_err(result_err),
    .done0(done0), .done1(done1), .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic logic [MW-1:0] madd(input logic [MW-1:0] a, input logic [MW-1:0] b,
                                         input int m, input int n);
    logic [MW-1:0]     s;
    logic [ELEM_W-1:0] e;
    s = '0;
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++)
        if (r < m && c < n) begin
          e = a[(r*MAX_DIM+c)*ELEM_W +: ELEM_W] + b[(r*MAX_DIM+c)*ELEM_W +: ELEM_W];
          s[(r*MAX_DIM+c)*ELEM_W +: ELEM_W] = e;
        end
    return s;
  endfunction

  function automatic logic [MW-1:0] put(input logic [MW-1:0] v, input int r, input int c, input int x);
    v[(r*MAX_DIM+c)*ELEM_W +: ELEM_W] = ELEM_W'(x);
    return v;
  endfunction

  function automatic logic [MW-1:0] rand_bus();
    logic [MW-1:0] v;
    for (int i = 0; i < MW; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  function automatic bit legal(input int m, input int n);
    return m >= 1 && m <= MAX_DIM && n >= 1 && n <= MAX_DIM;
  endfunction

  // Behavioural adder: element-wise wrap-around sum inside the m x n window.
  always_comb au_sum = madd(au_a, au_b, int'(au_m), int'(au_n));

  // Model state: pending flags, last-served requester, and the one job in flight.
  bit            mp0, mp1, mowner, job_on, job_ok;
  int            job_who, job_left;
  logic [MW-1:0] job_sum;
  logic [2:0]    exp_au_m, exp_au_n;
  logic [MW-1:0] exp_au_a, exp_au_b, exp_result;
  logic          exp_err, exp_done0, exp_done1, exp_busy, exp_owner;

  task automatic model_reset();
    mp0 = 0; mp1 = 0; mowner = 1; job_on = 0; job_ok = 0; job_who = 0; job_left = 0;
    job_sum = '0; exp_au_m = '0; exp_au_n = '0; exp_au_a = '0; exp_au_b = '0;
    exp_result = '0; exp_err = 0; exp_done0 = 0; exp_done1 = 0; exp_busy = 0; exp_owner = 1;
  endtask

  // Advance the model across the coming clock edge using the inputs now driven.
  task automatic model_step();
    bit cap, gr;
    int w;
    if (reset) begin
      model_reset();
      return;
    end
    exp_done0 = 0;
    exp_done1 = 0;
    cap = job_on && job_left == 1;
    gr  = !job_on && (mp0 || mp1);
    if (cap) begin
      if (job_ok) begin
        exp_result = job_sum;
        exp_err    = au_error | ~au_valid;
      end else begin
        exp_result = '0;
        exp_err    = 1;
      end
      if (job_who == 0) exp_done0 = 1; else exp_done1 = 1;
      job_on = 0;
    end else if (job_on) begin
      job_left--;
    end
    if (gr) begin
      if (mp0 && mp1) w = FIXED ? 0 : (mowner ? 0 : 1);
      else            w = mp1 ? 1 : 0;
      if (w == 0) mp0 = 0; else mp1 = 0;
      mowner   = (w == 1);
      job_on   = 1;
      job_who  = w;
      job_ok   = (w == 0) ? legal(int'(m0), int'(n0)) : legal(int'(m1), int'(n1));
      job_left = job_ok ? SETTLE : 1;
      if (job_ok) begin
        exp_au_m = (w == 0) ? m0 : m1;
        exp_au_n = (w == 0) ? n0 : n1;
        exp_au_a = (w == 0) ? a0 : a1;
        exp_au_b = (w == 0) ? b0 : b1;
        job_sum  = madd(exp_au_a, exp_au_b, int'(exp_au_m), int'(exp_au_n));
      end
    end
    mp0 = mp0 | req0;
    mp1 = mp1 | req1;
    exp_busy  = job_on;
    exp_owner = mowner;
  endtask

  task automatic chk(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Compare process: every cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("result",     result,             exp_result);
      chk("result_err", MW'(result_err),    MW'(exp_err));
      chk("done0",      MW'(done0),         MW'(exp_done0));
      chk("done1",      MW'(done1),         MW'(exp_done1));
      chk("busy",       MW'(busy),          MW'(exp_busy));
      chk("owner",      MW'(owner),         MW'(exp_owner));
      chk("au_m",       MW'(au_m),          MW'(exp_au_m));
      chk("au_n",       MW'(au_n),          MW'(exp_au_n));
      chk("au_a",       au_a,               exp_au_a);
      chk("au_b",       au_b,               exp_au_b);
      chk("done_excl",  MW'(done0 & done1), '0);
    end
  end

  // Drive one cycle of inputs at a falling edge, update the model, move to the next falling edge.
  task automatic step(input logic r0, input logic r1, input logic rs);
    reset = rs;
    req0  = r0;
    req1  = r1;
    model_step();
    @(negedge clk);
  endtask

  logic [MW-1:0] lit_a, lit_b, lit_s;
  int            cnt;
  bit            idle0, idle1;
  logic          r0, r1, rs;
  int            x;

  initial begin
    reset = 1; req0 = 0; req1 = 0; au_valid = 1; au_error = 0;
    m0 = 0; n0 = 0; m1 = 0; n1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_reset();
    @(negedge clk);
    step(0, 0, 1);
    chk_en = 1;
    chk("rst_owner", MW'(owner), MW'(1'b1));
    chk("rst_busy",  MW'(busy),  '0);
    chk("rst_res",   result,     '0);
    chk("rst_aum",   MW'(au_m),  '0);
    step(0, 0, 0);

    // Single op: [1 2 3;3 4 5] + [3 3 3;2 2 2]
    lit_a = '0; lit_b = '0; lit_s = '0;
    lit_a = put(lit_a, 0, 0, 1); lit_a = put(lit_a, 0, 1, 2); lit_a = put(lit_a, 0, 2, 3);
    lit_a = put(lit_a, 1, 0, 3); lit_a = put(lit_a, 1, 1, 4); lit_a = put(lit_a, 1, 2, 5);
    for (int c = 0; c < 3; c++) begin
      lit_b = put(lit_b, 0, c, 3);
      lit_b = put(lit_b, 1, c, 2);
      lit_s = put(lit_s, 0, c, 4 + c);
      lit_s = put(lit_s, 1, c, 5 + c);
    end
    m0 = 3'd2; n0 = 3'd3; a0 = lit_a; b0 = lit_b;
    step(1, 0, 0);
    step(0, 0, 0);
    chk("single_busy",  MW'(busy),  MW'(1'b1));
    chk("single_early", MW'(done0), '0);
    step(0, 0, 0);
    chk("single_done0", MW'(done0),      MW'(1'b1));
    chk("single_done1", MW'(done1),      '0);
    chk("single_res",   result,          lit_s);
    chk("single_err",   MW'(result_err), '0);
    step(0, 0, 0);
    chk("single_pulse", MW'(done0), '0);

    // Simultaneous requests after reset: 0 then 1, three times.
    step(0, 0, 1);
    step(0, 0, 0);
    m1 = 3'd3; n1 = 3'd2; a1 = rand_bus(); b1 = rand_bus();
    for (int p = 0; p < 3; p++) begin
      step(1, 1, 0);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("pair_first0", MW'(done0), MW'(1'b1));
      chk("pair_first1", MW'(done1), '0);
      step(0, 0, 0);
      step(0, 0, 0);
      chk("pair_second1", MW'(done1), MW'(1'b1));
      chk("pair_owner",   MW'(owner), MW'(1'b1));
    end

    // Illegal dims on requester 1
    m1 = 3'd0; n1 = 3'd3;
    step(0, 1, 0);
    step(0, 0, 0);
    chk("rej_busy", MW'(busy), MW'(1'b1));
    step(0, 0, 0);
    chk("rej_done1", MW'(done1),      MW'(1'b1));
    chk("rej_res",   result,          '0);
    chk("rej_err",   MW'(result_err), MW'(1'b1));
    chk("rej_aum",   MW'(au_m),       MW'(3'd3));
    chk("rej_aun",   MW'(au_n),       MW'(3'd2));

    // Adder reports error
    au_valid = 0; au_error = 1;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("aerr_err", MW'(result_err), MW'(1'b1));
    chk("aerr_res", result,          lit_s);
    au_valid = 1; au_error = 0;

    // Re-requests: one queued on the grant edge, one absorbed while pending
    cnt = 0;
    step(1, 0, 0); cnt += int'(done0);
    step(1, 0, 0); cnt += int'(done0);
    step(1, 0, 0); cnt += int'(done0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      cnt += int'(done0);
    end
    chk("requeue_count", MW'(cnt), MW'(2));

    // Reset one cycle after grant
    step(1, 0, 0);
    step(0, 0, 0);
    chk("mid_busy", MW'(busy), MW'(1'b1));
    step(0, 0, 1);
    chk("mid_rst_busy",  MW'(busy),  '0);
    chk("mid_rst_owner", MW'(owner), MW'(1'b1));
    chk("mid_rst_res",   result,     '0);
    chk("mid_rst_aum",   MW'(au_m),  '0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0);
      cnt += int'(done0 | done1);
    end
    chk("mid_no_done", MW'(cnt), '0);
    m1 = 3'd2; n1 = 3'd2;
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("mid_after_done1", MW'(done1), MW'(1'b1));
    chk("mid_after_res",   result,     madd(a1, b1, 2, 2));

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle0 = !mp0 && !(job_on && job_who == 0);
      idle1 = !mp1 && !(job_on && job_who == 1);
      r0 = 0; r1 = 0;
      if (idle0) begin
        if ($urandom_range(0, 3) == 0) begin
          m0 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, MAX_DIM)) : 3'($urandom_range(0, 7));
          n0 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, MAX_DIM)) : 3'($urandom_range(0, 7));
          a0 = rand_bus(); b0 = rand_bus();
          r0 = 1;
        end
      end else if ($urandom_range(0, 7) == 0) r0 = 1;
      if (idle1) begin
        if ($urandom_range(0, 3) == 0) begin
          m1 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, MAX_DIM)) : 3'($urandom_range(0, 7));
          n1 = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, MAX_DIM)) : 3'($urandom_range(0, 7));
          a1 = rand_bus(); b1 = rand_bus();
          r1 = 1;
        end
      end else if ($urandom_range(0, 7) == 0) r1 = 1;
      x = $urandom_range(0, 15);
      au_valid = !(x == 0 || x == 2);
      au_error = (x == 1 || x == 2);
      rs = ($urandom_range(0, 299) == 0);
      if (rs) begin
        r0 = 0;
        r1 = 0;
      end
      step(r0, r1, rs);
    end

    step(0, 0, 0);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
